ysyx_24110006_axi_rd_arbiter: RTL

Two-master, one-slave AXI4 read-channel arbiter. It shares the single AXI read port between the instruction cache (master 0) and the LSU (master 1). The block sits between the two fetch/load units and the memory-side AXI interconnect. Exactly one read transaction is in flight at a time; it is owned by one master from address grant until its last data beat.

---
 rtl/ysyx_24110006_axi_rd_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_24110006_axi_rd_arbiter.sv
// Purpose: shares one AXI4 read port between icache (m0) and LSU (m1), one transaction in flight.
// Latency: request sampled in IDLE is issued next cycle; R channel is combinational in DATA.
// Backpressure: owner's rready drives slave rready directly; losing master waits with arready=0.
module ysyx_24110006_axi_rd_arbiter #(
  parameter int RR   = 1,
  parameter int ID_W = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  // master 0 (icache)
  input  logic [31:0]     i_m0_axi_araddr,
  input  logic            i_m0_axi_arvalid,
  output logic            o_m0_axi_arready,
  input  logic [ID_W-1:0] i_m0_axi_arid,
  input  logic [7:0]      i_m0_axi_arlen,
  input  logic [2:0]      i_m0_axi_arsize,
  input  logic [1:0]      i_m0_axi_arburst,
  output logic [31:0]     o_m0_axi_rdata,
  output logic            o_m0_axi_rvalid,
  input  logic            i_m0_axi_rready,
  output logic [1:0]      o_m0_axi_rresp,
  output logic [ID_W-1:0] o_m0_axi_rid,
  output logic            o_m0_axi_rlast,
  // master 1 (LSU)
  input  logic [31:0]     i_m1_axi_araddr,
  input  logic            i_m1_axi_arvalid,
  output logic            o_m1_axi_arready,
  input  logic [ID_W-1:0] i_m1_axi_arid,
  input  logic [7:0]      i_m1_axi_arlen,
  input  logic [2:0]      i_m1_axi_arsize,
  input  logic [1:0]      i_m1_axi_arburst,
  output logic [31:0]     o_m1_axi_rdata,
  output logic            o_m1_axi_rvalid,
  input  logic            i_m1_axi_rready,
  output logic [1:0]      o_m1_axi_rresp,
  output logic [ID_W-1:0] o_m1_axi_rid,
  output logic            o_m1_axi_rlast,
  // slave
  output logic [31:0]     o_axi_araddr,
  output logic [ID_W-1:0] o_axi_arid,
  output logic [7:0]      o_axi_arlen,
  output logic [2:0]      o_axi_arsize,
  output logic [1:0]      o_axi_arburst,
  output logic            o_axi_arvalid,
  input  logic            i_axi_arready,
  input  logic [31:0]     i_axi_rdata,
  input  logic [1:0]      i_axi_rresp,
  input  logic [ID_W-1:0] i_axi_rid,
  input  logic            i_axi_rlast,
  input  logic            i_axi_rvalid,
  output logic            o_axi_rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;  // owning master
  logic   last_q,  last_d;   // most recently granted master

  logic in_addr, in_data;
  logic m0_own, m1_own;

  // Granted master's request, selected by grant_q
  logic            g_arvalid;
  logic [31:0]     g_araddr;
  logic [ID_W-1:0] g_arid;
  logic [7:0]      g_arlen;
  logic [2:0]      g_arsize;
  logic [1:0]      g_arburst;
  logic            g_rready;

  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign m0_own  = ~grant_q;
  assign m1_own  = grant_q;

  assign g_arvalid = grant_q ? i_m1_axi_arvalid : i_m0_axi_arvalid;
  assign g_araddr  = grant_q ? i_m1_axi_araddr  : i_m0_axi_araddr;
  assign g_arid    = grant_q ? i_m1_axi_arid    : i_m0_axi_arid;
  assign g_arlen   = grant_q ? i_m1_axi_arlen   : i_m0_axi_arlen;
  assign g_arsize  = grant_q ? i_m1_axi_arsize  : i_m0_axi_arsize;
  assign g_arburst = grant_q ? i_m1_axi_arburst : i_m0_axi_arburst;
  assign g_rready  = grant_q ? i_m1_axi_rready  : i_m0_axi_rready;

  // AR channel: only live in ADDR, payload zeroed otherwise
  assign o_axi_arvalid    = in_addr & g_arvalid;
  assign o_axi_araddr     = in_addr ? g_araddr  : '0;
  assign o_axi_arid       = in_addr ? g_arid    : '0;
  assign o_axi_arlen      = in_addr ? g_arlen   : '0;
  assign o_axi_arsize     = in_addr ? g_arsize  : '0;
  assign o_axi_arburst    = in_addr ? g_arburst : '0;
  assign o_m0_axi_arready = in_addr & m0_own & i_axi_arready;
  assign o_m1_axi_arready = in_addr & m1_own & i_axi_arready;

  // R channel: routed to the owner in DATA only; slave beats outside DATA are held off
  assign o_axi_rready    = in_data & g_rready;
  assign o_m0_axi_rvalid = in_data & m0_own & i_axi_rvalid;
  assign o_m1_axi_rvalid = in_data & m1_own & i_axi_rvalid;
  assign o_m0_axi_rdata  = (in_data & m0_own) ? i_axi_rdata : '0;
  assign o_m0_axi_rresp  = (in_data & m0_own) ? i_axi_rresp : '0;
  assign o_m0_axi_rid    = (in_data & m0_own) ? i_axi_rid   : '0;
  assign o_m0_axi_rlast  = in_data & m0_own & i_axi_rlast;
  assign o_m1_axi_rdata  = (in_data & m1_own) ? i_axi_rdata : '0;
  assign o_m1_axi_rresp  = (in_data & m1_own) ? i_axi_rresp : '0;
  assign o_m1_axi_rid    = (in_data & m1_own) ? i_axi_rid   : '0;
  assign o_m1_axi_rlast  = in_data & m1_own & i_axi_rlast;

  // Next-state: arbitration in IDLE, AR handshake/abandon in ADDR, rlast release in DATA
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_m0_axi_arvalid || i_m1_axi_arvalid) begin
          if (i_m0_axi_arvalid && i_m1_axi_arvalid) begin
            // tie: round-robin favours the master not served last; fixed mode favours m1
            grant_d = (RR != 0) ? ~last_q : 1'b1;
          end else begin
            grant_d = i_m1_axi_arvalid;
          end
          last_d  = grant_d;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (g_arvalid && i_axi_arready) begin
          state_d = DATA;
        end else if (!g_arvalid) begin
          // requester withdrew before anything was issued
          state_d = IDLE;
        end
      end
      DATA: begin
        if (i_axi_rvalid && g_rready && i_axi_rlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last starts at 1 so m0 wins the first round-robin tie
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule
